// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle multiply/divide unit for the E stage; owns HI/LO.
// The result is computed combinationally when the operation is accepted and
// held in pending registers. It is committed to HI/LO when the busy countdown
// ends, so the old HI/LO values stay readable for the whole busy period.
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   synchronous active-high reset; aborts any operation in flight
//   Start  in   E-stage instruction is mult/multu/div/divu
//   MDUOp  in   [2:0] 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none
//   A      in   [31:0] rs operand
//   B      in   [31:0] rt operand
//   Busy   out  operation in flight (registered)
//   HI     out  [31:0] HI register
//   LO     out  [31:0] LO register
module mul_div_unit #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Start,
   input  logic [2:0]  MDUOp,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int unsigned CW = $clog2(DIV_CYCLES + 1);

   localparam logic [2:0] OpMult  = 3'd1;
   localparam logic [2:0] OpMultu = 3'd2;
   localparam logic [2:0] OpDiv   = 3'd3;
   localparam logic [2:0] OpDivu  = 3'd4;
   localparam logic [2:0] OpMthi  = 3'd5;
   localparam logic [2:0] OpMtlo  = 3'd6;

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e          state;
   logic [CW-1:0]   count;
   logic [31:0]     pend_hi;
   logic [31:0]     pend_lo;

   logic            is_op;
   logic            is_div;
   logic [63:0]     prod_s;
   logic [63:0]     prod_u;
   logic [31:0]     div_b;
   logic [31:0]     quot_s;
   logic [31:0]     rem_s;
   logic [31:0]     quot_u;
   logic [31:0]     rem_u;
   logic [31:0]     res_hi;
   logic [31:0]     res_lo;

   assign is_op  = (MDUOp >= OpMult) && (MDUOp <= OpDivu);
   assign is_div = (MDUOp == OpDiv) || (MDUOp == OpDivu);

   // Operands explicitly widened so the 64-bit products need no context extension.
   assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
   assign prod_u = {32'b0, A} * {32'b0, B};

   // Substitute 1 for a zero divisor so the dividers never see x; the result is unused then.
   assign div_b  = (B == 32'd0) ? 32'd1 : B;
   assign quot_s = $signed(A) / $signed(div_b);
   assign rem_s  = $signed(A) % $signed(div_b);
   assign quot_u = A / div_b;
   assign rem_u  = A % div_b;

   always_comb begin
      // Default keeps HI/LO, which is also the divide-by-zero result.
      res_hi = HI;
      res_lo = LO;
      case (MDUOp)
         OpMult:  {res_hi, res_lo} = prod_s;
         OpMultu: {res_hi, res_lo} = prod_u;
         OpDiv: begin
            if (B == 32'd0) begin
               res_hi = HI;
               res_lo = LO;
            end else if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
               res_hi = 32'd0;
               res_lo = 32'h8000_0000;
            end else begin
               res_hi = rem_s;
               res_lo = quot_s;
            end
         end
         OpDivu: begin
            if (B != 32'd0) begin
               res_hi = rem_u;
               res_lo = quot_u;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= StIdle;
         Busy    <= 1'b0;
         count   <= '0;
         HI      <= 32'd0;
         LO      <= 32'd0;
         pend_hi <= 32'd0;
         pend_lo <= 32'd0;
      end else begin
         case (state)
            StIdle: begin
               if (Start && is_op) begin
                  state   <= StRun;
                  Busy    <= 1'b1;
                  pend_hi <= res_hi;
                  pend_lo <= res_lo;
                  count   <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
               end else if (MDUOp == OpMthi) begin
                  HI <= A;
               end else if (MDUOp == OpMtlo) begin
                  LO <= A;
               end
            end
            StRun: begin
               // Start, MTHI and MTLO are all ignored while running.
               if (count == CW'(1)) begin
                  state <= StIdle;
                  Busy  <= 1'b0;
                  count <= '0;
                  HI    <= pend_hi;
                  LO    <= pend_lo;
               end else begin
                  count <= count - CW'(1);
               end
            end
            default: begin
               state <= StIdle;
               Busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed bench for mul_div_unit with hand-computed results.
module tb_mul_div_unit;

   logic        clk;
   logic        reset;
   logic        Start;
   logic [2:0]  MDUOp;
   logic [31:0] A;
   logic [31:0] B;
   logic        Busy;
   logic [31:0] HI;
   logic [31:0] LO;

   int errors;
   int checks;

   mul_div_unit #(
      .MULT_CYCLES(5),
      .DIV_CYCLES (10)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .Start(Start),
      .MDUOp(MDUOp),
      .A    (A),
      .B    (B),
      .Busy (Busy),
      .HI   (HI),
      .LO   (LO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Issue one op, count busy cycles (bounded), verify HI/LO hold and the final result.
   // inj_at > 0 pulses Start+MULT (5*5) during that busy cycle; it must be ignored.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int exp_n,
                         input logic [31:0] old_hi, input logic [31:0] old_lo,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input int inj_at);
      int   n;
      logic held;
      @(negedge clk);
      Start = 1'b1; MDUOp = op; A = a; B = b;
      @(negedge clk);
      Start = 1'b0; MDUOp = 3'd0; A = 32'd0; B = 32'd0;
      n    = 0;
      held = 1'b1;
      while (Busy && n < 50) begin
         n++;
         if (HI !== old_hi || LO !== old_lo) held = 1'b0;
         if (n == inj_at) begin
            Start = 1'b1; MDUOp = 3'd1; A = 32'd5; B = 32'd5;
         end
         @(negedge clk);
         if (n == inj_at) begin
            Start = 1'b0; MDUOp = 3'd0; A = 32'd0; B = 32'd0;
         end
      end
      check({tag, " busy_cycles"}, 32'(n), 32'(exp_n));
      check({tag, " hold"}, {31'd0, held}, 32'd1);
      check({tag, " HI"}, HI, exp_hi);
      check({tag, " LO"}, LO, exp_lo);
   endtask

   initial begin
      int n;
      errors = 0;
      checks = 0;
      reset = 1'b1; Start = 1'b0; MDUOp = 3'd0; A = 32'd0; B = 32'd0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("reset Busy", {31'd0, Busy}, 32'd0);
      check("reset HI", HI, 32'd0);
      check("reset LO", LO, 32'd0);

      run_op("mult", 3'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'd0, 32'd0,
             32'hFFFF_FFFF, 32'hFFFF_FFFA, 0);
      run_op("multu", 3'd2, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA,
             32'h0000_0002, 32'hFFFF_FFFA, 0);
      run_op("div", 3'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'h0000_0002, 32'hFFFF_FFFA,
             32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
      run_op("divu", 3'd4, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
             32'h0000_0001, 32'h7FFF_FFFC, 0);
      run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0001, 32'h7FFF_FFFC,
             32'h0000_0000, 32'h8000_0000, 0);

      // MTHI with Start high still writes HI.
      @(negedge clk);
      Start = 1'b1; MDUOp = 3'd5; A = 32'h33;
      @(negedge clk);
      Start = 1'b0; MDUOp = 3'd0; A = 32'd0;
      check("mthi_start Busy", {31'd0, Busy}, 32'd0);
      check("mthi_start HI", HI, 32'h33);

      // Preload HI/LO.
      MDUOp = 3'd5; A = 32'h11;
      @(negedge clk);
      MDUOp = 3'd6; A = 32'h22;
      @(negedge clk);
      MDUOp = 3'd0; A = 32'd0;
      check("mt Busy", {31'd0, Busy}, 32'd0);
      check("mthi HI", HI, 32'h11);
      check("mtlo LO", LO, 32'h22);

      run_op("div0", 3'd3, 32'd100, 32'd0, 10, 32'h11, 32'h22, 32'h11, 32'h22, 0);

      // 100/7 = 14 r 2, with an ignored MULT pulse in busy cycle 4.
      run_op("div_inj", 3'd3, 32'd100, 32'd7, 10, 32'h11, 32'h22, 32'd2, 32'd14, 4);

      // Reset in busy cycle 3 of a MULT aborts it.
      @(negedge clk);
      Start = 1'b1; MDUOp = 3'd1; A = 32'd7; B = 32'd6;
      @(negedge clk);
      Start = 1'b0; MDUOp = 3'd0; A = 32'd0; B = 32'd0;
      n = 1;
      while (Busy && n < 3) begin
         n++;
         @(negedge clk);
      end
      check("abort reached busy3", {31'd0, Busy}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort Busy", {31'd0, Busy}, 32'd0);
      check("abort HI", HI, 32'd0);
      check("abort LO", LO, 32'd0);
      repeat (8) @(negedge clk);
      check("abort late Busy", {31'd0, Busy}, 32'd0);
      check("abort late HI", HI, 32'd0);
      check("abort late LO", LO, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
